// File: rtl/rxstatus_scheduler.sv
// Captures receive-path event pulses into a pending set and reports them one PIPE RXSTATUS code at a time, by fixed priority.
// Optional DROP_COUNT output (saturating drop counter) is compiled in with RXSTATUS_DROPCNT_EN.
module rxstatus_scheduler #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       SKP_ADDED,
  input  logic       SKP_REMOVED,
  input  logic       RXDET_O,
  input  logic       DECODE_ERROR,
  input  logic       BUFF_OVERFLOW,
  input  logic       BUFF_UNDERFLOW,
  input  logic       DISPARITY_ERROR,
  input  logic       CLR_DROP,
  output logic [2:0] RXSTATUS,
  output logic       STATUS_VALID,
  output logic [6:0] PENDING,
  output logic       DROPPED
`ifdef RXSTATUS_DROPCNT_EN
  ,
  output logic [7:0] DROP_COUNT
`endif
);

  typedef enum logic {IDLE, REPORT} state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [2:0] code_nxt;
  logic       valid_nxt;
  logic [6:0] pend_nxt;
  logic [6:0] retire;
  logic [6:0] drops;
  logic       dropped_nxt;
  logic [6:0] events;

  assign events = {SKP_ADDED, SKP_REMOVED, RXDET_O, DECODE_ERROR,
                   BUFF_OVERFLOW, BUFF_UNDERFLOW, DISPARITY_ERROR};

  // Priority: decode, disparity, overflow, underflow, skp added, skp removed, rxdet.
  function automatic logic [2:0] pick_code(input logic [6:0] v);
    if      (v[3]) return 3'b100;
    else if (v[0]) return 3'b111;
    else if (v[2]) return 3'b101;
    else if (v[1]) return 3'b110;
    else if (v[6]) return 3'b001;
    else if (v[5]) return 3'b010;
    else if (v[4]) return 3'b011;
    else           return 3'b000;
  endfunction

  function automatic logic [6:0] code_mask(input logic [2:0] code);
    case (code)
      3'b001:  return 7'b1000000;
      3'b010:  return 7'b0100000;
      3'b011:  return 7'b0010000;
      3'b100:  return 7'b0001000;
      3'b101:  return 7'b0000100;
      3'b110:  return 7'b0000010;
      3'b111:  return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    code_nxt  = RXSTATUS;
    pend_nxt  = PENDING;
    retire    = '0;
    drops     = '0;
    if (ENABLE) begin
      case (state)
        IDLE: begin
          pend_nxt = PENDING | events;
          drops    = events & PENDING;
          if (|pend_nxt) begin
            code_nxt  = pick_code(pend_nxt);
            hold_nxt  = HOLD_LOAD;
            state_nxt = REPORT;
          end
        end
        REPORT: begin
          if (hold_cnt != 4'd0) begin
            hold_nxt = hold_cnt - 4'd1;
            pend_nxt = PENDING | events;
            drops    = events & PENDING;
          end else begin
            // A bit retired on this edge may re-arrive without counting as a drop.
            retire   = code_mask(RXSTATUS);
            pend_nxt = (PENDING & ~retire) | events;
            drops    = events & PENDING & ~retire;
            if (|pend_nxt) begin
              code_nxt = pick_code(pend_nxt);
              hold_nxt = HOLD_LOAD;
            end else begin
              code_nxt  = 3'b000;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    valid_nxt = |code_nxt;
    if (|drops)        dropped_nxt = 1'b1;
    else if (CLR_DROP) dropped_nxt = 1'b0;
    else               dropped_nxt = DROPPED;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      RXSTATUS     <= '0;
      STATUS_VALID <= 1'b0;
      PENDING      <= '0;
      DROPPED      <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      RXSTATUS     <= code_nxt;
      STATUS_VALID <= valid_nxt;
      PENDING      <= pend_nxt;
      DROPPED      <= dropped_nxt;
    end
  end

`ifdef RXSTATUS_DROPCNT_EN
  logic [2:0] drop_num;
  logic [8:0] drop_sum;
  logic [7:0] count_nxt;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < 7; i++) drop_num = drop_num + 3'(drops[i]);
    drop_sum = {1'b0, DROP_COUNT} + 9'(drop_num);
    // A clear on a dropping edge restarts the count from that edge's drops.
    if (CLR_DROP)         count_nxt = 8'(drop_num);
    else if (drop_sum[8]) count_nxt = 8'hFF;
    else                  count_nxt = drop_sum[7:0];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) DROP_COUNT <= '0;
    else       DROP_COUNT <= count_nxt;
  end
`endif

endmodule
